// File: rtl/data_collector_if.sv
// Handshake/bus bundle between a word producer, the data_collector and the frame consumer.
// RUNNING_MIN_EN adds the run_min signal to both modports.
interface data_collector_if #(
    parameter int WORD_WIDTH = 8,
    parameter int DATA_LEN   = 16
);
    localparam int CNT_W = $clog2(DATA_LEN + 1);

    logic                           clear;
    logic                           in_valid;
    logic [WORD_WIDTH-1:0]          in_data;
    logic                           in_ready;
    logic [WORD_WIDTH*DATA_LEN-1:0] data_out;
    logic                           out_valid;
    logic                           out_ack;
    logic [CNT_W-1:0]               fill_count;
`ifdef RUNNING_MIN_EN
    logic [WORD_WIDTH-1:0]          run_min;

    modport master (output clear, in_valid, in_data, out_ack,
                    input  in_ready, data_out, out_valid, fill_count, run_min);
    modport slave  (input  clear, in_valid, in_data, out_ack,
                    output in_ready, data_out, out_valid, fill_count, run_min);
`else
    modport master (output clear, in_valid, in_data, out_ack,
                    input  in_ready, data_out, out_valid, fill_count);
    modport slave  (input  clear, in_valid, in_data, out_ack,
                    output in_ready, data_out, out_valid, fill_count);
`endif
endinterface

// File: rtl/data_collector.sv
// Serial-to-parallel frame loader: packs DATA_LEN words into a flat bus and holds it until acked.
// Optional feature macro: RUNNING_MIN_EN (running minimum of the current frame on run_min).
module data_collector #(
    parameter int WORD_WIDTH = 8,
    parameter int DATA_LEN   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    data_collector_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_LEN + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [WORD_WIDTH*DATA_LEN-1:0] data_q, data_d;
    logic                           accept;

    // The word counter doubles as the write index: in FILL both are equal.
    assign bus.in_ready   = (state_q == FILL) & rst_n;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.data_out   = data_q;
    assign bus.fill_count = cnt_q;
    assign accept         = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (bus.clear) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < DATA_LEN; k++)
                            if (cnt_q == CNT_W'(k))
                                data_d[WORD_WIDTH*k +: WORD_WIDTH] = bus.in_data;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_LEN - 1))
                            state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ack) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

`ifdef RUNNING_MIN_EN
    logic [WORD_WIDTH-1:0] run_min_q, run_min_d;

    assign bus.run_min = run_min_q;

    always_comb begin
        run_min_d = run_min_q;
        if (bus.clear)
            run_min_d = '0;
        else if (accept && state_q == FILL) begin
            if (cnt_q == '0 || bus.in_data < run_min_q)
                run_min_d = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) run_min_q <= '0;
        else        run_min_q <= run_min_d;
    end
`endif
endmodule

// File: tb/tb_data_collector.sv
// Directed bench for data_collector: packing, hold/ack, gaps, clear, reset, optional running min.
module tb_data_collector;
    localparam int WW = 8;
    localparam int DL = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] exp_frame;
    logic [127:0] snap;
    int   cnt;

    always #5 clk = ~clk;

    data_collector_if #(.WORD_WIDTH(WW), .DATA_LEN(DL)) bus ();

    data_collector #(.WORD_WIDTH(WW), .DATA_LEN(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ack = 1'b0;
        step(); step();
        // 1: reset state and back-to-back fill
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_fill_count", 128'(bus.fill_count), 128'd0);
        chk("rst_data_out", bus.data_out, 128'd0);
        chk("rst_in_ready_low", 128'(bus.in_ready), 128'd0);
`ifdef RUNNING_MIN_EN
        chk("rst_run_min", 128'(bus.run_min), 128'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 128'(bus.in_ready), 128'd1);
        exp_frame = '0;
        for (int k = 0; k < 16; k++) begin
            exp_frame[8*k +: 8] = 8'(k);
            push(8'(k));
            if (k == 14) chk("t1_no_early_valid", 128'(bus.out_valid), 128'd0);
        end
        chk("t1_out_valid", 128'(bus.out_valid), 128'd1);
        chk("t1_slot0", 128'(bus.data_out[7:0]), 128'h00);
        chk("t1_slot15", 128'(bus.data_out[127:120]), 128'h0F);
        chk("t1_frame", bus.data_out, exp_frame);
        chk("t1_fill_count", 128'(bus.fill_count), 128'd16);

        // 2: HOLD ignores in_valid, ack releases, next word lands in slot 0
        bus.in_valid = 1'b1; bus.in_data = 8'hAA;
        for (int i = 0; i < 5; i++) step();
        bus.in_valid = 1'b0;
        chk("t2_in_ready", 128'(bus.in_ready), 128'd0);
        chk("t2_hold_data", bus.data_out, exp_frame);
        chk("t2_hold_count", 128'(bus.fill_count), 128'd16);
        chk("t2_hold_valid", 128'(bus.out_valid), 128'd1);
        ack();
        chk("t2_ack_valid", 128'(bus.out_valid), 128'd0);
        chk("t2_ack_ready", 128'(bus.in_ready), 128'd1);
        chk("t2_ack_count", 128'(bus.fill_count), 128'd0);
        push(8'h55);
        exp_frame[7:0] = 8'h55;
        chk("t2_word55", bus.data_out, exp_frame);
        chk("t2_count1", 128'(bus.fill_count), 128'd1);
        bus.clear = 1'b1; step(); bus.clear = 1'b0;
        chk("t2_clear_count", 128'(bus.fill_count), 128'd0);
        chk("t2_clear_keeps_data", 128'(bus.data_out[7:0]), 128'h55);

        // 3: in_valid toggling every other cycle
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = (i % 2 == 0) ? 8'(i / 2) : 8'hEE;
            step();
            if (i % 2 == 0) cnt++;
            if (i < 31) chk("t3_count", 128'(bus.fill_count), 128'(cnt));
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) exp_frame[8*k +: 8] = 8'(k);
        chk("t3_out_valid", 128'(bus.out_valid), 128'd1);
        chk("t3_frame", bus.data_out, exp_frame);
        chk("t3_count16", 128'(bus.fill_count), 128'd16);
        ack();

        // 4: clear with a concurrent word drops that word
        for (int k = 0; k < 7; k++) begin
            push(8'h10 + 8'(k));
            exp_frame[8*k +: 8] = 8'h10 + 8'(k);
        end
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
        step();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        chk("t4_clear_count", 128'(bus.fill_count), 128'd0);
        chk("t4_clear_valid", 128'(bus.out_valid), 128'd0);
        chk("t4_dropped_77", bus.data_out, exp_frame);
`ifdef RUNNING_MIN_EN
        chk("t4_clear_run_min", 128'(bus.run_min), 128'd0);
`endif
        for (int k = 0; k < 16; k++) begin
            push(8'h20 + 8'(k));
            exp_frame[8*k +: 8] = 8'h20 + 8'(k);
            if (k == 14) chk("t4_no_early_valid", 128'(bus.out_valid), 128'd0);
        end
        chk("t4_out_valid", 128'(bus.out_valid), 128'd1);
        chk("t4_frame", bus.data_out, exp_frame);
        ack();

        // 5: reset mid-frame
        for (int k = 0; k < 9; k++) push(8'h30 + 8'(k));
        chk("t5_count9", 128'(bus.fill_count), 128'd9);
        rst_n = 1'b0;
        step();
        chk("t5_valid", 128'(bus.out_valid), 128'd0);
        chk("t5_count", 128'(bus.fill_count), 128'd0);
        chk("t5_data", bus.data_out, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_ready", 128'(bus.in_ready), 128'd1);

`ifdef RUNNING_MIN_EN
        // 6: running minimum, no carry-over between frames
        for (int k = 0; k < 16; k++) push((k == 9) ? 8'h03 : 8'hF0 - 8'(k));
        chk("t6_valid", 128'(bus.out_valid), 128'd1);
        chk("t6_min03", 128'(bus.run_min), 128'h03);
        snap = 128'(bus.run_min);
        bus.in_valid = 1'b1; bus.in_data = 8'h01; step(); bus.in_valid = 1'b0;
        chk("t6_hold_min", 128'(bus.run_min), snap);
        ack();
        for (int k = 0; k < 16; k++) push(8'hFF);
        chk("t6_minFF", 128'(bus.run_min), 128'hFF);
        ack();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
